// File: rtl/fir_mac_sequencer.sv
// 16-tap FIR over one ADC channel, sharing a single multiply-accumulate unit.
// Define FIR_SAT_EN to saturate y instead of wrapping it to OUT_W bits.
module fir_mac_sequencer #(
    parameter int WIDTH     = 36,
    parameter int TAPS      = 16,
    parameter int COEF_W    = 12,
    parameter int DIV       = 64,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 11
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [11:0]              sample_in,
    input  logic                     coef_we,
    input  logic [3:0]               coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic signed [OUT_W-1:0]  y,
    output logic                     y_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(TAPS);
    localparam int PW = 13 + COEF_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MAC  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]                state;
    logic [CW-1:0]             cnt;
    logic [IW-1:0]             idx;
    logic signed [WIDTH-1:0]   acc;
    logic signed [12:0]        d    [TAPS];
    logic signed [COEF_W-1:0]  coef [TAPS];

    logic                      tick;
    logic signed [12:0]        x;
    logic signed [PW-1:0]      prod;
    logic signed [WIDTH-1:0]   prod_ext;
    logic signed [OUT_W-1:0]   y_next;

    assign tick     = (cnt == CW'(DIV - 1));
    // Offset-binary to two's complement: flip the MSB, then sign-extend.
    assign x        = {~sample_in[11], ~sample_in[11], sample_in[10:0]};
    assign prod     = d[idx] * coef[idx];
    assign prod_ext = {{(WIDTH-PW){prod[PW-1]}}, prod};
    assign busy     = (state != IDLE);

`ifdef FIR_SAT_EN
    localparam logic signed [WIDTH-1:0] YMAX =
        {{(WIDTH-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] YMIN =
        {{(WIDTH-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [WIDTH-1:0] shifted;
    assign shifted = acc >>> OUT_SHIFT;

    always_comb begin
        y_next = shifted[OUT_W-1:0];
        if (shifted > YMAX)
            y_next = YMAX[OUT_W-1:0];
        else if (shifted < YMIN)
            y_next = YMIN[OUT_W-1:0];
    end
`else
    always_comb begin
        y_next = OUT_W'(acc >>> OUT_SHIFT);
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            acc     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            overrun <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                d[k]    <= '0;
                coef[k] <= '0;
            end
        end else begin
            cnt     <= tick ? '0 : cnt + 1'b1;
            y_valid <= 1'b0;

            if (coef_we && (32'(coef_addr) < TAPS))
                coef[coef_addr] <= coef_data;

            // A tick arriving while the MAC is still busy is lost.
            if (tick && (state != IDLE))
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (tick) begin
                        d[0] <= x;
                        for (int k = 1; k < TAPS; k++)
                            d[k] <= d[k-1];
                        idx   <= '0;
                        acc   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    idx <= idx + 1'b1;
                    if (idx == IW'(TAPS - 1)) begin
                        idx   <= '0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    y       <= y_next;
                    y_valid <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench: two sequencers (fast/unshifted and overrunning/shifted)
// checked against a dot-product reference computed at each accepted tick.
module tb_fir_mac_sequencer;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [11:0]        sample_in = '0;
    logic               coef_we = 1'b0;
    logic [3:0]         coef_addr = '0;
    logic signed [11:0] coef_data = '0;

    logic signed [15:0] ya, yb;
    logic               yva, yvb, busya, busyb, ovra, ovrb;

    always #5 clock = ~clock;

    fir_mac_sequencer #(.DIV(20), .OUT_SHIFT(0)) ua (
        .clock(clock), .reset(reset), .sample_in(sample_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .y(ya), .y_valid(yva), .busy(busya), .overrun(ovra)
    );

    fir_mac_sequencer #(.DIV(16)) ub (
        .clock(clock), .reset(reset), .sample_in(sample_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .y(yb), .y_valid(yvb), .busy(busyb), .overrun(ovrb)
    );

    int n_chk = 0;
    int n_fail = 0;
    int n = 0;
    int capa = -1000;
    int capb = -1000;
    bit eba = 0, ebb = 0, eoa = 0, eob = 0;
    int da [16];
    int db [16];
    int cm [16];
    logic signed [15:0] qa[$];
    logic signed [15:0] qb[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic signed [15:0] fir_ref(input int d[16],
                                                   input int c[16],
                                                   input int sh);
        longint sum = 0;
        longint v;
        for (int k = 0; k < 16; k++)
            sum += longint'(d[k]) * longint'(c[k]);
        v = sum >>> sh;
`ifdef FIR_SAT_EN
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
`endif
        return 16'(v);
    endfunction

    function automatic logic [11:0] samp(input int mode, input int e);
        case (mode)
            0: return (e <= 20) ? 12'd2049 : 12'd2048;
            1: return 12'd4095;
            2: return 12'd0;
            3: return 12'd4095;
            default: return 12'($urandom_range(0, 4095));
        endcase
    endfunction

    function automatic int coef_for(input int mode, input int k);
        case (mode)
            0: return k + 1;
            1, 2: return 1;
            3: return 2047;
            default: return int'($urandom_range(0, 4095)) - 2048;
        endcase
    endfunction

    // Called at a falling edge: drives inputs for the next rising edge,
    // models that edge, then waits for the following falling edge.
    task automatic step(input logic [11:0] s, input bit we,
                        input int a, input int dv);
        sample_in = s;
        coef_we   = we;
        coef_addr = 4'(a);
        coef_data = 12'(dv);
        if (we) cm[a] = dv;
        n++;
        if (n % 20 == 0) begin
            if (n - capa >= 18) begin
                for (int k = 15; k > 0; k--) da[k] = da[k-1];
                da[0] = int'(s) - 2048;
                capa = n;
                qa.push_back(fir_ref(da, cm, 0));
            end else eoa = 1;
        end
        if (n % 16 == 0) begin
            if (n - capb >= 18) begin
                for (int k = 15; k > 0; k--) db[k] = db[k-1];
                db[0] = int'(s) - 2048;
                capb = n;
                qb.push_back(fir_ref(db, cm, 11));
            end else eob = 1;
        end
        eba = (n - capa <= 16);
        ebb = (n - capb <= 16);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        coef_we = 1'b0;
        qa.delete();
        qb.delete();
        for (int k = 0; k < 16; k++) begin
            da[k] = 0; db[k] = 0; cm[k] = 0;
        end
        n = 0; capa = -1000; capb = -1000;
        eba = 0; ebb = 0; eoa = 0; eob = 0;
        @(negedge clock);
        chk("reset_ya", ya, 0);
        chk("reset_yb", yb, 0);
        chk("reset_yva", yva, 0);
        chk("reset_ovrb", ovrb, 0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic phase(input int mode, input int run);
        do_reset();
        for (int k = 0; k < 16; k++)
            step(samp(mode, n + 1), 1'b1, k, coef_for(mode, k));
        for (int i = 0; i < run; i++)
            step(samp(mode, n + 1), 1'b0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (qa.size() == 0 && qb.size() == 0) break;
            step(12'($urandom_range(0, 4095)), 1'b0, 0, 0);
        end
        chk("drain_pending", qa.size() + qb.size(), 0);
    endtask

    always @(posedge clock) begin
        #1;
        if (yva) begin
            if (qa.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL ya_unexpected: got valid y=%0d, required no output", ya);
            end else chk("ya", ya, qa.pop_front());
        end
        if (yvb) begin
            if (qb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL yb_unexpected: got valid y=%0d, required no output", yb);
            end else chk("yb", yb, qb.pop_front());
        end
        chk("busya", busya, eba);
        chk("busyb", busyb, ebb);
        chk("overruna", ovra, eoa);
        chk("overrunb", ovrb, eob);
    end

    initial begin
        @(negedge clock);
        phase(0, 400); drain();
        phase(1, 400); drain();
        phase(2, 400); drain();
        phase(3, 200); drain();
        phase(4, 1200); drain();
        phase(4, 12);
        phase(0, 400); drain();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
